// File: rtl/am_pkg.sv
// Shared definitions for the 40GBASE-R alignment marker lanes (TX insert / RX lock).
package am_pkg;

  localparam logic [1:0] SYNC_HEAD_CTRL = 2'b10;
  localparam int         BIP_W          = 8;

  // Payload byte i sits at [8i +: 8]; bytes 3 and 7 carry BIP3/BIP7 and are masked out.
  localparam logic [63:0] AM_MATCH_MASK = 64'h00ff_ffff_00ff_ffff;
  localparam logic [63:0] AM_LANE0_ENC  = 64'h00b8_896f_0047_7690;
  localparam logic [63:0] AM_LANE1_ENC  = 64'h0019_3b0f_00e6_c4f0;
  localparam logic [63:0] AM_LANE2_ENC  = 64'h0064_9a3a_009b_65c5;
  localparam logic [63:0] AM_LANE3_ENC  = 64'h00c2_865d_003d_79a2;

  typedef enum logic [1:0] {
    FIND    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } am_state_t;

endpackage

// File: rtl/am_bip_step.sv
// One block of Bit Interleaved Parity: payload bit k folds onto bip[k mod 8],
// sync header bits 0/1 land on bip[3]/bip[4].
module am_bip_step
  import am_pkg::*;
#(
  parameter int HEAD_W = 2,
  parameter int DATA_W = 64
) (
  input  logic [BIP_W-1:0]         bip_prev,
  input  logic [HEAD_W+DATA_W-1:0] block,
  input  logic                     restart,
  output logic [BIP_W-1:0]         bip_next
);

  logic [DATA_W-1:0] payload;
  logic [BIP_W-1:0]  acc;

  always_comb begin
    payload = block[HEAD_W+DATA_W-1:HEAD_W];
    acc     = restart ? '0 : bip_prev;
    for (int k = 0; k < DATA_W / BIP_W; k++) begin
      acc     = acc ^ payload[BIP_W-1:0];
      payload = payload >> BIP_W;
    end
    acc[3]   = acc[3] ^ block[0];
    acc[4]   = acc[4] ^ block[1];
    bip_next = acc;
  end

endmodule

// File: rtl/am_lane_rx.sv
// Per-lane RX alignment marker stage: marker lock, marker drop and BIP3 checking.
//
//   state   | meaning
//   FIND    | hunting for any block that matches the lane marker
//   CONFIRM | one marker seen; expecting the next one AM_GAP+1 blocks later
//   LOCKED  | marker positions known; drop them, check BIP, count misses
module am_lane_rx
  import am_pkg::*;
#(
  parameter int                       HEAD_W   = 2,
  parameter int                       DATA_W   = 64,
  parameter int                       BLOCK_W  = HEAD_W + DATA_W,
  parameter logic [DATA_W-1:0]        LANE_ENC = AM_LANE0_ENC,
  parameter int                       AM_GAP   = 16383,
  parameter int                       MAX_MISS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               block_lock_i,
  input  logic               valid_i,
  input  logic [BLOCK_W-1:0] data_i,
  output logic               valid_o,
  output logic [BLOCK_W-1:0] data_o,
  output logic               marker_v_o,
  output logic               am_lock_o,
  output logic               bip_err_o,
  output logic [15:0]        bip_err_cnt_o
);

  localparam int                GAP_W      = $clog2(AM_GAP + 1);
  localparam int                MISS_W     = $clog2(MAX_MISS + 1);
  localparam logic [DATA_W-1:0] MATCH_MASK = DATA_W'(AM_MATCH_MASK);

  am_state_t         state;
  logic [GAP_W-1:0]  gap_cnt;
  logic [MISS_W-1:0] miss_cnt;
  logic [BIP_W-1:0]  bip_acc;
  logic [BIP_W-1:0]  bip_next;
  logic [BIP_W-1:0]  rx_bip3;
  logic              is_match;
  logic              at_pos;
  logic              bip_restart;

  assign is_match = (data_i[HEAD_W-1:0] == SYNC_HEAD_CTRL) &&
                    ((data_i[BLOCK_W-1:HEAD_W] & MATCH_MASK) == (LANE_ENC & MATCH_MASK));
  assign at_pos   = (gap_cnt == GAP_W'(AM_GAP));
  assign rx_bip3  = data_i[HEAD_W + 3*BIP_W +: BIP_W];

  // Every marker position (matched or not) starts a fresh parity period.
  assign bip_restart = (state == FIND) ? is_match : at_pos;

  am_bip_step #(
    .HEAD_W (HEAD_W),
    .DATA_W (DATA_W)
  ) u_bip_step (
    .bip_prev (bip_acc),
    .block    (data_i),
    .restart  (bip_restart),
    .bip_next (bip_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= FIND;
      gap_cnt       <= '0;
      miss_cnt      <= '0;
      bip_acc       <= '0;
      valid_o       <= 1'b0;
      data_o        <= '0;
      marker_v_o    <= 1'b0;
      am_lock_o     <= 1'b0;
      bip_err_o     <= 1'b0;
      bip_err_cnt_o <= '0;
    end else if (!block_lock_i) begin
      state      <= FIND;
      gap_cnt    <= '0;
      miss_cnt   <= '0;
      bip_acc    <= '0;
      am_lock_o  <= 1'b0;
      marker_v_o <= 1'b0;
      bip_err_o  <= 1'b0;
      valid_o    <= valid_i;
      if (valid_i) data_o <= data_i;
    end else if (!valid_i) begin
      valid_o    <= 1'b0;
      marker_v_o <= 1'b0;
      bip_err_o  <= 1'b0;
    end else begin
      data_o     <= data_i;
      valid_o    <= 1'b1;
      marker_v_o <= 1'b0;
      bip_err_o  <= 1'b0;
      bip_acc    <= bip_next;
      unique case (state)
        FIND: begin
          if (is_match) begin
            gap_cnt <= '0;
            state   <= CONFIRM;
          end
        end
        CONFIRM: begin
          if (at_pos) begin
            gap_cnt <= '0;
            if (is_match) begin
              state     <= LOCKED;
              am_lock_o <= 1'b1;
            end else begin
              state <= FIND;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        LOCKED: begin
          if (at_pos) begin
            gap_cnt    <= '0;
            valid_o    <= 1'b0;
            marker_v_o <= 1'b1;
            if (is_match) begin
              miss_cnt <= '0;
              if (bip_acc != rx_bip3) begin
                bip_err_o <= 1'b1;
                if (bip_err_cnt_o != 16'hffff) bip_err_cnt_o <= bip_err_cnt_o + 1'b1;
              end
            end else if (miss_cnt == MISS_W'(MAX_MISS - 1)) begin
              state     <= FIND;
              am_lock_o <= 1'b0;
              miss_cnt  <= '0;
            end else begin
              miss_cnt <= miss_cnt + 1'b1;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= FIND;
      endcase
    end
  end

endmodule

// File: tb/tb_am_lane_rx.sv
// Directed bench for am_lane_rx with AM_GAP=7, MAX_MISS=4 and a lane-0 TX marker model.
module tb_am_lane_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        block_lock_i;
  logic        valid_i;
  logic [65:0] data_i;
  logic        valid_o;
  logic [65:0] data_o;
  logic        marker_v_o;
  logic        am_lock_o;
  logic        bip_err_o;
  logic [15:0] bip_err_cnt_o;

  int          n_vec = 0;
  int          n_err = 0;
  int          bad;
  logic [7:0]  tx_bip;
  logic [65:0] mk;

  always #5 clk = ~clk;

  am_lane_rx #(
    .AM_GAP   (7),
    .MAX_MISS (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .block_lock_i  (block_lock_i),
    .valid_i       (valid_i),
    .data_i        (data_i),
    .valid_o       (valid_o),
    .data_o        (data_o),
    .marker_v_o    (marker_v_o),
    .am_lock_o     (am_lock_o),
    .bip_err_o     (bip_err_o),
    .bip_err_cnt_o (bip_err_cnt_o)
  );

  // Bit-serial parity: walk every block bit and drop it onto its BIP lane.
  function automatic logic [7:0] f_blk(input logic [65:0] b);
    logic [7:0]  p;
    logic [65:0] t;
    p = '0;
    t = b;
    for (int n = 0; n < 66; n++) begin
      if (t[0]) begin
        if (n == 0)      p = p ^ 8'h08;
        else if (n == 1) p = p ^ 8'h10;
        else             p = p ^ (8'h01 << ((n - 2) % 8));
      end
      t = t >> 1;
    end
    return p;
  endfunction

  function automatic logic [65:0] mk_marker(input logic [7:0] bip);
    logic [63:0] p;
    p = {~bip, 8'hb8, 8'h89, 8'h6f, bip, 8'h47, 8'h76, 8'h90};
    return {p, 2'b10};
  endfunction

  task automatic cycle(input logic [65:0] blk, input logic v);
    data_i  = blk;
    valid_i = v;
    @(posedge clk);
    #1;
  endtask

  task automatic send_marker(input logic [65:0] cmask);
    mk = mk_marker(tx_bip) ^ cmask;
    cycle(mk, 1'b1);
    tx_bip = f_blk(mk);
  endtask

  // flip_at corrupts one block on the wire only; the TX parity keeps the clean value.
  task automatic send_data(input int n, input int flip_at, input bit stall);
    logic [65:0] blk;
    logic [65:0] sent;
    logic [65:0] prev;
    for (int i = 0; i < n; i++) begin
      if (stall && (i % 2 == 1)) begin
        for (int s = 0; s < 1 + (i % 3); s++) begin
          prev = data_o;
          cycle({$urandom(), $urandom(), 2'b10}, 1'b0);
          if (valid_o !== 1'b0 || marker_v_o !== 1'b0 || bip_err_o !== 1'b0 || data_o !== prev) bad++;
        end
      end
      blk    = {$urandom(), $urandom(), 2'b01};
      tx_bip = tx_bip ^ f_blk(blk);
      sent   = (i == flip_at) ? (blk ^ (66'd1 << 10)) : blk;
      cycle(sent, 1'b1);
      if (valid_o !== 1'b1 || marker_v_o !== 1'b0 || bip_err_o !== 1'b0 || data_o !== sent) bad++;
    end
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    block_lock_i = 1'b1;
    cycle(mk_marker(8'h00), 1'b1);
    cycle(mk_marker(8'h00), 1'b1);
    reset  = 1'b0;
    tx_bip = 8'h00;
    bad    = 0;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    block_lock_i = 1'b1;
    cycle(mk_marker(8'h5a), 1'b1);
    cycle(mk_marker(8'h5a), 1'b1);
    n_vec++; if ({valid_o, marker_v_o, am_lock_o, bip_err_o} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags: got %b want 0000", {valid_o, marker_v_o, am_lock_o, bip_err_o}); end
    n_vec++; if (data_o !== 66'd0) begin n_err++; $display("FAIL reset_data: got %h want 0", data_o); end
    n_vec++; if (bip_err_cnt_o !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", bip_err_cnt_o); end
    reset = 1'b0;
  endtask

  task automatic test_lock_acq();
    do_reset();
    send_data(3, -1, 1'b0);
    send_marker('0);
    n_vec++; if ({marker_v_o, valid_o, am_lock_o} !== 3'b010 || data_o !== mk) begin
      n_err++; $display("FAIL acq_m1: got mv/v/lk %b want 010", {marker_v_o, valid_o, am_lock_o}); end
    send_data(7, -1, 1'b0);
    n_vec++; if (am_lock_o !== 1'b0) begin n_err++; $display("FAIL acq_pre_m2: got lk %b want 0", am_lock_o); end
    send_marker('0);
    n_vec++; if ({marker_v_o, valid_o, am_lock_o} !== 3'b011) begin
      n_err++; $display("FAIL acq_m2: got mv/v/lk %b want 011", {marker_v_o, valid_o, am_lock_o}); end
    for (int k = 0; k < 2; k++) begin
      send_data(7, -1, 1'b0);
      send_marker('0);
      n_vec++; if ({marker_v_o, valid_o, am_lock_o, bip_err_o} !== 4'b1010 || data_o !== mk) begin
        n_err++; $display("FAIL acq_m%0d: got mv/v/lk/err %b want 1010", k + 3, {marker_v_o, valid_o, am_lock_o, bip_err_o}); end
    end
    n_vec++; if (bad !== 0 || bip_err_cnt_o !== 16'd0) begin
      n_err++; $display("FAIL acq_data: got bad=%0d cnt=%0d want 0/0", bad, bip_err_cnt_o); end
  endtask

  task automatic test_false_match();
    do_reset();
    send_marker('0);
    send_data(8, -1, 1'b0);
    send_data(8, -1, 1'b0);
    n_vec++; if (am_lock_o !== 1'b0 || bad !== 0) begin
      n_err++; $display("FAIL false_match: got lk=%b bad=%0d want 0/0", am_lock_o, bad); end
    send_marker('0);
    send_data(7, -1, 1'b0);
    send_marker('0);
    n_vec++; if (am_lock_o !== 1'b1) begin n_err++; $display("FAIL false_relock: got lk %b want 1", am_lock_o); end
  endtask

  task automatic test_lock_loss();
    logic [65:0] cm [0:2];
    cm[0] = 66'h4;
    cm[1] = 66'h3;
    cm[2] = 66'd1 << 50;
    do_reset();
    send_marker('0);
    send_data(7, -1, 1'b0);
    send_marker('0);
    for (int i = 0; i < 3; i++) begin
      send_data(7, -1, 1'b0);
      send_marker(cm[i]);
      n_vec++; if ({marker_v_o, valid_o, am_lock_o, bip_err_o} !== 4'b1010) begin
        n_err++; $display("FAIL miss_a%0d: got mv/v/lk/err %b want 1010", i, {marker_v_o, valid_o, am_lock_o, bip_err_o}); end
    end
    send_data(7, -1, 1'b0);
    send_marker('0);
    n_vec++; if ({marker_v_o, valid_o, am_lock_o, bip_err_o} !== 4'b1010) begin
      n_err++; $display("FAIL miss_good: got mv/v/lk/err %b want 1010", {marker_v_o, valid_o, am_lock_o, bip_err_o}); end
    for (int i = 0; i < 3; i++) begin
      send_data(7, -1, 1'b0);
      send_marker(cm[i]);
    end
    n_vec++; if (am_lock_o !== 1'b1) begin n_err++; $display("FAIL miss_b3: got lk %b want 1", am_lock_o); end
    send_data(7, -1, 1'b0);
    send_marker(cm[0]);
    n_vec++; if ({marker_v_o, valid_o, am_lock_o} !== 3'b100) begin
      n_err++; $display("FAIL miss_b4: got mv/v/lk %b want 100", {marker_v_o, valid_o, am_lock_o}); end
    send_data(7, -1, 1'b0);
    send_marker('0);
    n_vec++; if ({marker_v_o, valid_o, am_lock_o} !== 3'b010) begin
      n_err++; $display("FAIL loss_m1: got mv/v/lk %b want 010", {marker_v_o, valid_o, am_lock_o}); end
    send_data(7, -1, 1'b0);
    send_marker('0);
    n_vec++; if ({marker_v_o, valid_o, am_lock_o} !== 3'b011) begin
      n_err++; $display("FAIL loss_m2: got mv/v/lk %b want 011", {marker_v_o, valid_o, am_lock_o}); end
    n_vec++; if (bad !== 0 || bip_err_cnt_o !== 16'd0) begin
      n_err++; $display("FAIL loss_data: got bad=%0d cnt=%0d want 0/0", bad, bip_err_cnt_o); end
  endtask

  task automatic test_bip_err();
    do_reset();
    send_marker('0);
    send_data(7, -1, 1'b0);
    send_marker('0);
    send_data(7, 2, 1'b0);
    send_marker('0);
    n_vec++; if ({marker_v_o, bip_err_o} !== 2'b11 || bip_err_cnt_o !== 16'd1) begin
      n_err++; $display("FAIL bip_hit: got mv/err %b cnt %0d want 11/1", {marker_v_o, bip_err_o}, bip_err_cnt_o); end
    send_data(1, -1, 1'b0);
    n_vec++; if (bip_err_o !== 1'b0) begin n_err++; $display("FAIL bip_pulse: got err %b want 0", bip_err_o); end
    send_data(6, -1, 1'b0);
    send_marker('0);
    n_vec++; if (bip_err_o !== 1'b0 || bip_err_cnt_o !== 16'd1) begin
      n_err++; $display("FAIL bip_clean: got err %b cnt %0d want 0/1", bip_err_o, bip_err_cnt_o); end
    send_data(7, 6, 1'b0);
    send_marker('0);
    n_vec++; if (bip_err_o !== 1'b1 || bip_err_cnt_o !== 16'd2) begin
      n_err++; $display("FAIL bip_hit2: got err %b cnt %0d want 1/2", bip_err_o, bip_err_cnt_o); end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL bip_data: got bad=%0d want 0", bad); end
  endtask

  task automatic test_reset_mid();
    send_data(3, -1, 1'b0);
    reset = 1'b1;
    cycle({$urandom(), $urandom(), 2'b01}, 1'b1);
    n_vec++; if ({valid_o, marker_v_o, am_lock_o, bip_err_o} !== 4'b0000 || data_o !== 66'd0 || bip_err_cnt_o !== 16'd0) begin
      n_err++; $display("FAIL rst_mid: got v/mv/lk/err %b cnt %0d want 0000/0", {valid_o, marker_v_o, am_lock_o, bip_err_o}, bip_err_cnt_o); end
    reset = 1'b0;
    send_data(3, -1, 1'b0);
    send_marker('0);
    n_vec++; if ({marker_v_o, valid_o, am_lock_o} !== 3'b010) begin
      n_err++; $display("FAIL rst_m1: got mv/v/lk %b want 010", {marker_v_o, valid_o, am_lock_o}); end
    send_data(7, -1, 1'b0);
    send_marker('0);
    n_vec++; if (am_lock_o !== 1'b1) begin n_err++; $display("FAIL rst_m2: got lk %b want 1", am_lock_o); end
  endtask

  task automatic test_stall();
    do_reset();
    send_marker('0);
    send_data(7, -1, 1'b1);
    send_marker('0);
    n_vec++; if (am_lock_o !== 1'b1) begin n_err++; $display("FAIL stall_lock: got lk %b want 1", am_lock_o); end
    for (int k = 0; k < 2; k++) begin
      send_data(7, -1, 1'b1);
      cycle(mk_marker(8'h00), 1'b0);
      send_marker('0);
      n_vec++; if ({marker_v_o, am_lock_o, bip_err_o} !== 3'b110) begin
        n_err++; $display("FAIL stall_m%0d: got mv/lk/err %b want 110", k, {marker_v_o, am_lock_o, bip_err_o}); end
    end
    send_data(3, -1, 1'b0);
    block_lock_i = 1'b0;
    send_data(1, -1, 1'b0);
    n_vec++; if (am_lock_o !== 1'b0) begin n_err++; $display("FAIL blk_drop: got lk %b want 0", am_lock_o); end
    block_lock_i = 1'b1;
    send_data(3, -1, 1'b0);
    send_marker('0);
    n_vec++; if ({marker_v_o, am_lock_o} !== 2'b00) begin
      n_err++; $display("FAIL blk_m1: got mv/lk %b want 00", {marker_v_o, am_lock_o}); end
    send_data(7, -1, 1'b1);
    send_marker('0);
    n_vec++; if (am_lock_o !== 1'b1) begin n_err++; $display("FAIL blk_m2: got lk %b want 1", am_lock_o); end
    send_data(7, -1, 1'b0);
    send_marker('0);
    n_vec++; if ({marker_v_o, bip_err_o} !== 2'b10 || bad !== 0) begin
      n_err++; $display("FAIL blk_m3: got mv/err %b bad=%0d want 10/0", {marker_v_o, bip_err_o}, bad); end
  endtask

  initial begin
    reset        = 1'b1;
    block_lock_i = 1'b1;
    valid_i      = 1'b0;
    data_i       = '0;
    tx_bip       = 8'h00;
    bad          = 0;
    mk           = '0;
    test_reset();
    test_lock_acq();
    test_false_match();
    test_lock_loss();
    test_stall();
    test_bip_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
